// File: rtl/weapon_swing_ctrl.sv
// Melee/archer attack sequencer: turns left-mouse presses into frame-timed weapon swings
// with one damage pulse per swing. Optional build macro: WEAPON_SWING_AUTOFIRE_EN.
module weapon_swing_ctrl #(
  parameter int SWING_STEP      = 3,
  parameter int SWING_FRAMES    = 8,
  parameter int HOLD_FRAMES     = 4,
  parameter int COOLDOWN_FRAMES = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_vsync,
  input  logic        i_mouse_left,
  input  logic [1:0]  i_game_active,
  input  logic        i_alive,
  input  logic [1:0]  i_char_class,
  input  logic        i_melee_hit,
  output logic        o_attack_active,
  output logic [11:0] o_anim_x_offset,
  output logic        o_damage_pulse,
  output logic        o_busy
);

  localparam int MAX_FRAMES_A = (SWING_FRAMES > HOLD_FRAMES) ? SWING_FRAMES : HOLD_FRAMES;
  localparam int MAX_FRAMES   = (MAX_FRAMES_A > COOLDOWN_FRAMES) ? MAX_FRAMES_A : COOLDOWN_FRAMES;
  localparam int CNT_W        = $clog2(MAX_FRAMES + 1);

  localparam logic [11:0]      STEP    = 12'(SWING_STEP);
  localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(SWING_FRAMES - 1);
  localparam logic [CNT_W-1:0] HD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXTEND,
    S_HOLD,
    S_RETRACT,
    S_COOLDOWN
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [11:0]      r_offset, w_offset_next;
  logic             r_hit_done, w_hit_done_next;
  logic             r_attack_active, w_attack_next;
  logic             r_vsync_q;
  logic             r_mouse_q;

  logic w_enable;
  logic w_melee;
  logic w_archer;
  logic w_tick;
  logic w_start;
  logic w_swing_phase;
  logic w_next_swing_phase;
  logic w_pulse;

  assign w_enable      = (i_game_active != 2'b00) && i_alive;
  assign w_melee       = (i_char_class == 2'b01);
  assign w_archer      = (i_char_class == 2'b10);
  assign w_tick        = i_vsync & ~r_vsync_q;
  assign w_swing_phase = (r_state == S_EXTEND) || (r_state == S_HOLD) || (r_state == S_RETRACT);

`ifdef WEAPON_SWING_AUTOFIRE_EN
  // Held button keeps re-arming a swing whenever the FSM is back in IDLE.
  assign w_start = i_mouse_left;
`else
  assign w_start = i_mouse_left & ~r_mouse_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_offset        <= '0;
      r_hit_done      <= 1'b0;
      r_attack_active <= 1'b0;
      r_vsync_q       <= 1'b0;
      r_mouse_q       <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_offset        <= w_offset_next;
      r_hit_done      <= w_hit_done_next;
      r_attack_active <= w_attack_next;
      r_vsync_q       <= i_vsync;
      r_mouse_q       <= i_mouse_left;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_offset_next   = r_offset;
    w_hit_done_next = r_hit_done;
    w_pulse         = 1'b0;

    if (!w_enable || !w_melee) begin
      // Losing enable or leaving melee class aborts at once and skips cooldown.
      w_state_next  = S_IDLE;
      w_cnt_next    = '0;
      w_offset_next = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_offset_next = '0;
          if (w_start) begin
            w_state_next    = S_EXTEND;
            w_cnt_next      = '0;
            w_hit_done_next = 1'b0;
          end
        end
        S_EXTEND: begin
          if (w_tick) begin
            w_offset_next = r_offset + STEP;
            if (r_cnt == SW_LAST) begin
              w_state_next = S_HOLD;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            if (r_cnt == HD_LAST) begin
              w_state_next = S_RETRACT;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
        end
        S_RETRACT: begin
          if (w_tick) begin
            if (r_offset <= STEP) begin
              w_offset_next = '0;
              w_state_next  = S_COOLDOWN;
              w_cnt_next    = '0;
            end else begin
              w_offset_next = r_offset - STEP;
            end
          end
        end
        S_COOLDOWN: begin
          w_offset_next = '0;
          if (w_tick) begin
            if (r_cnt == CD_LAST) begin
              w_state_next = S_IDLE;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + CNT_ONE;
            end
          end
        end
        default: begin
          w_state_next  = S_IDLE;
          w_cnt_next    = '0;
          w_offset_next = '0;
        end
      endcase

      if (w_swing_phase && i_melee_hit && !r_hit_done) begin
        w_pulse         = 1'b1;
        w_hit_done_next = 1'b1;
      end
    end
  end

  assign w_next_swing_phase = (w_state_next == S_EXTEND) || (w_state_next == S_HOLD) ||
                              (w_state_next == S_RETRACT);
  assign w_attack_next = (w_melee && w_enable && w_next_swing_phase) ||
                         (w_archer && w_enable && i_mouse_left);

  assign o_attack_active = r_attack_active;
  assign o_anim_x_offset = r_offset;
  assign o_damage_pulse  = w_pulse;
  assign o_busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_weapon_swing_ctrl.sv
// Randomized bench for weapon_swing_ctrl; reference model tracks frame ticks since swing start.
module tb_weapon_swing_ctrl;

  localparam int STEP     = 3;
  localparam int SF       = 8;
  localparam int HF       = 4;
  localparam int CF       = 12;
  localparam int SWING_END = 2 * SF + HF;
  localparam int TOTAL     = SWING_END + CF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        mouse_left = 1'b0;
  logic [1:0]  game_active = 2'b00;
  logic        alive = 1'b0;
  logic [1:0]  char_class = 2'b00;
  logic        melee_hit = 1'b0;
  logic        attack_active;
  logic [11:0] anim_x_offset;
  logic        damage_pulse;
  logic        busy;

  int vec_count  = 0;
  int miscompares = 0;
  int cycle_no   = 0;
  int swings_done = 0;

  // Reference model state
  bit m_swing, m_hit_done, m_archer, m_vsq, m_mq;
  int m_ticks;
  int vs_cnt, vs_period;

  weapon_swing_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_vsync         (vsync),
    .i_mouse_left    (mouse_left),
    .i_game_active   (game_active),
    .i_alive         (alive),
    .i_char_class    (char_class),
    .i_melee_hit     (melee_hit),
    .o_attack_active (attack_active),
    .o_anim_x_offset (anim_x_offset),
    .o_damage_pulse  (damage_pulse),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_count++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cycle_no, obs, exp_v);
    end
  endtask

  function automatic int exp_offset(input int k);
    if (k <= SF)            return STEP * k;
    else if (k <= SF + HF)  return STEP * SF;
    else if (k <= SWING_END) return STEP * (SWING_END - k);
    else                    return 0;
  endfunction

  task automatic drive_vsync();
    vs_cnt++;
    if (vs_cnt >= vs_period) begin
      vs_cnt    = 0;
      vs_period = $urandom_range(4, 9);
    end
    vsync = (vs_cnt < 2);
  endtask

  // Called right after inputs change at the falling edge.
  task automatic check_and_step();
    bit en, tick, start, pulse_exp;
    #1;
    en   = (game_active != 2'b00) && alive;
    tick = vsync && !m_vsq;
`ifdef WEAPON_SWING_AUTOFIRE_EN
    start = mouse_left;
`else
    start = mouse_left && !m_mq;
`endif
    pulse_exp = en && (char_class == 2'b01) && m_swing && (m_ticks < SWING_END) &&
                melee_hit && !m_hit_done;
    check_eq("damage_pulse", 32'(damage_pulse), 32'(pulse_exp));

    m_archer = mouse_left && en && (char_class == 2'b10);
    if (!en || char_class != 2'b01) begin
      m_swing = 1'b0;
    end else if (!m_swing) begin
      if (start) begin
        m_swing    = 1'b1;
        m_ticks    = 0;
        m_hit_done = 1'b0;
      end
    end else begin
      if (pulse_exp) m_hit_done = 1'b1;
      if (tick) begin
        m_ticks++;
        if (m_ticks == TOTAL) begin
          m_swing = 1'b0;
          swings_done++;
          $display("swing %0d complete at cycle %0d, hit_landed=%0d", swings_done, cycle_no, m_hit_done);
        end
      end
    end
    m_vsq = vsync;
    m_mq  = mouse_left;

    @(posedge clk);
    #1;
    cycle_no++;
    check_eq("anim_x_offset", 32'(anim_x_offset), m_swing ? 32'(exp_offset(m_ticks)) : 32'd0);
    check_eq("attack_active", 32'(attack_active), 32'((m_swing && m_ticks < SWING_END) || m_archer));
    check_eq("busy", 32'(busy), 32'(m_swing));
  endtask

  // mode 0: melee-heavy, 1: archer, 2: chaos, 3: melee with button held
  task automatic run_phase(input int mode, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      drive_vsync();
      case (mode)
        0: begin
          if ($urandom_range(0, 24) == 0) mouse_left = ~mouse_left;
          melee_hit   = ($urandom_range(0, 7) == 0);
          alive       = ($urandom_range(0, 399) != 0);
          game_active = ($urandom_range(0, 499) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
          char_class  = ($urandom_range(0, 599) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
        end
        1: begin
          if ($urandom_range(0, 9) == 0) mouse_left = ~mouse_left;
          melee_hit   = $urandom_range(0, 1);
          alive       = ($urandom_range(0, 19) != 0);
          game_active = 2'($urandom_range(0, 3));
          char_class  = 2'b10;
        end
        2: begin
          mouse_left  = $urandom_range(0, 1);
          melee_hit   = $urandom_range(0, 1);
          alive       = ($urandom_range(0, 7) != 0);
          game_active = 2'($urandom_range(0, 3));
          char_class  = 2'($urandom_range(0, 3));
        end
        default: begin
          mouse_left  = 1'b1;
          melee_hit   = ($urandom_range(0, 5) == 0);
          alive       = 1'b1;
          game_active = 2'b01;
          char_class  = 2'b01;
        end
      endcase
      check_and_step();
    end
  endtask

  initial begin
    vs_cnt    = 0;
    vs_period = 6;
    m_swing = 0; m_hit_done = 0; m_archer = 0; m_vsq = 0; m_mq = 0; m_ticks = 0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset_attack_active", 32'(attack_active), 32'd0);
    check_eq("reset_anim_x_offset", 32'(anim_x_offset), 32'd0);
    check_eq("reset_damage_pulse", 32'(damage_pulse), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);

    run_phase(0, 8000);
    run_phase(3, 2500);
    @(negedge clk);
    mouse_left = 1'b0;
    check_and_step();
    run_phase(1, 1500);
    run_phase(2, 1500);
    run_phase(0, 4000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
